// File: rtl/pillar_pkg.sv
// Shared constants and fetch FSM encoding for the front end of the core.
package pillar_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries; the head reads as zero when empty.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [W-1:0]           i_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [W-1:0]           o_head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + PTR_W'(1);
      if (i_pop)  r_rd <= r_rd + PTR_W'(1);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  // Storage carries no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_data;
  end

  assign o_count = r_count;
  assign o_head  = (r_count != '0) ? r_mem[r_rd] : '0;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one read at a time to RAM and buffers
// fetched words with their PCs for the control unit.
module fetch_unit
  import pillar_pkg::*;
#(
  parameter int                ADDR_W     = XLEN,
  parameter int                DATA_W     = XLEN,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_VECTOR),
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              instr_valid_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              instr_ready_i
);
  localparam int                CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES);

  fetch_state_e               r_state;
  fetch_state_e               w_state_nxt;
  logic [ADDR_W-1:0]          r_pc;
  logic [ADDR_W-1:0]          r_drain_addr;
  logic [ADDR_W-1:0]          w_redir_pc;
  logic [CNT_W-1:0]           w_count;
  logic [ADDR_W+DATA_W-1:0]   w_head;
  logic                       w_push;
  logic                       w_pop;

  assign w_redir_pc = redirect_pc_i & ~ADDR_W'(INSTR_BYTES - 1);
  assign w_push     = (r_state == S_REQ) && mem_ack_i && !redirect_i;
  assign w_pop      = instr_valid_o && instr_ready_i && !redirect_i;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (redirect_i || (w_count < DEPTH_C)) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (redirect_i) begin
          w_state_nxt = mem_ack_i ? S_REQ : S_DRAIN;
        end else if (mem_ack_i && !w_pop && (w_count >= LAST_C)) begin
          // This push fills the last slot; no room to issue another read.
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (mem_ack_i) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_i)  r_pc <= w_redir_pc;
      else if (w_push) r_pc <= r_pc + PC_STEP;
    end
  end

  // The abandoned request keeps its address on the bus until RAM acks it.
  always_ff @(posedge clk) begin
    if ((r_state == S_REQ) && redirect_i && !mem_ack_i) r_drain_addr <= r_pc;
  end

  assign mem_req_o  = (r_state == S_REQ) || (r_state == S_DRAIN);
  assign mem_addr_o = (r_state == S_DRAIN) ? r_drain_addr :
                      (r_state == S_REQ)   ? r_pc         : '0;

  fetch_fifo #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .i_data  ({r_pc, mem_data_i}),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign instr_valid_o         = (w_count != '0);
  assign {instr_pc_o, instr_o} = w_head;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic checked by a queue model.
module tb_fetch_unit;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_data_i;
  logic          redirect_i = 1'b0;
  logic [AW-1:0] redirect_pc_i = '0;
  logic          instr_valid_o;
  logic [DW-1:0] instr_o;
  logic [AW-1:0] instr_pc_o;
  logic          instr_ready_i = 1'b0;

  fetch_unit #(
    .ADDR_W(AW), .DATA_W(DW), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {~a[15:0] ^ a[31:16], a[15:0]} ^ 32'h1357_2468;
  endfunction

  // RAM model: ack after ack_lat waiting cycles, optionally gated by a random bit.
  int ack_lat   = 0;
  bit ack_rand  = 1'b0;
  bit ack_force = 1'b0;
  int wait_cnt  = 0;
  bit rnd_bit   = 1'b1;

  assign mem_ack_i  = ack_force || (mem_req_o && (wait_cnt >= ack_lat) && rnd_bit);
  assign mem_data_i = mem_word(mem_addr_o);

  always @(posedge clk) begin
    if (mem_req_o && !mem_ack_i) wait_cnt <= wait_cnt + 1;
    else                         wait_cnt <= 0;
    rnd_bit <= ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Reference model: expected buffered words, next accepted fetch PC, drain pending.
  logic [AW+DW-1:0] q[$];
  logic [AW-1:0]    m_pc    = '0;
  bit               m_stale = 1'b0;
  bit               mon_en  = 1'b0;
  int               n_pops  = 0;

  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      m_pc    = '0;
      m_stale = 1'b0;
    end else if (mon_en) begin
      n_tests++;
      if (instr_valid_o !== (q.size() != 0)) begin
        n_fail++;
        $display("FAIL mon_valid got %b exp %b", instr_valid_o, q.size() != 0);
      end
      if (instr_valid_o && q.size() != 0) begin
        n_tests++;
        if ({instr_pc_o, instr_o} !== q[0]) begin
          n_fail++;
          $display("FAIL mon_head got %h exp %h", {instr_pc_o, instr_o}, q[0]);
        end
      end
      if (mem_req_o && !m_stale) begin
        n_tests++;
        if (mem_addr_o !== m_pc) begin
          n_fail++;
          $display("FAIL mon_addr got %h exp %h", mem_addr_o, m_pc);
        end
      end
      if (redirect_i) begin
        q.delete();
        m_stale = mem_req_o && !mem_ack_i;
        m_pc    = redirect_pc_i & ~32'h3;
      end else begin
        if (instr_valid_o && instr_ready_i && q.size() != 0) begin
          void'(q.pop_front());
          n_pops++;
        end
        if (mem_req_o && mem_ack_i) begin
          if (m_stale) begin
            m_stale = 1'b0;
          end else begin
            q.push_back({m_pc, mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
            n_tests++;
            if (q.size() > DEPTH) begin
              n_fail++;
              $display("FAIL mon_overflow got %0d entries exp <= %0d", q.size(), DEPTH);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    redirect_i = 1'b0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_tests++; if (mem_req_o !== 1'b0)      begin n_fail++; $display("FAIL rst_req got %b exp 0", mem_req_o); end
    n_tests++; if (mem_addr_o !== '0)       begin n_fail++; $display("FAIL rst_addr got %h exp 0", mem_addr_o); end
    n_tests++; if (instr_valid_o !== 1'b0)  begin n_fail++; $display("FAIL rst_valid got %b exp 0", instr_valid_o); end
    n_tests++; if (instr_o !== '0)          begin n_fail++; $display("FAIL rst_instr got %h exp 0", instr_o); end
    n_tests++; if (instr_pc_o !== '0)       begin n_fail++; $display("FAIL rst_pc got %h exp 0", instr_pc_o); end
    mon_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int k = 0;
    ack_lat = 0; instr_ready_i = 1'b1;
    do_reset();
    @(negedge clk);
    while (!mem_req_o && k < 10) begin @(negedge clk); k++; end
    n_tests++; if (!mem_req_o) begin n_fail++; $display("FAIL b2b_start got req=0 exp 1"); end
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (mem_addr_o !== 32'(4 * i)) begin
        n_fail++; $display("FAIL b2b_addr got %h exp %h", mem_addr_o, 32'(4 * i));
      end
      if (i > 0) begin
        n_tests++;
        if (!instr_valid_o || instr_pc_o !== 32'(4 * (i - 1)) || instr_o !== mem_word(32'(4 * (i - 1)))) begin
          n_fail++; $display("FAIL b2b_head got v=%b %h/%h exp pc %h", instr_valid_o, instr_pc_o, instr_o, 32'(4 * (i - 1)));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ready_stall();
    int k = 0;
    ack_lat = 0; instr_ready_i = 1'b0;
    do_reset();
    repeat (8) @(negedge clk);
    n_tests++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL stall_req got %b exp 0", mem_req_o); end
    n_tests++;
    if (!instr_valid_o || instr_pc_o !== 32'h0 || instr_o !== mem_word(32'h0)) begin
      n_fail++; $display("FAIL stall_head got v=%b %h/%h exp pc 0", instr_valid_o, instr_pc_o, instr_o);
    end
    repeat (3) @(negedge clk);
    n_tests++; if (instr_pc_o !== 32'h0) begin n_fail++; $display("FAIL stall_hold got %h exp 0", instr_pc_o); end
    step();
    instr_ready_i = 1'b1;
    @(negedge clk);
    while (!mem_req_o && k < 10) begin @(negedge clk); k++; end
    n_tests++;
    if (!mem_req_o || mem_addr_o !== 32'h8) begin
      n_fail++; $display("FAIL stall_resume got req=%b addr %h exp addr 8", mem_req_o, mem_addr_o);
    end
  endtask

  task automatic test_redirect_drain();
    int k = 0;
    ack_lat = 3; instr_ready_i = 1'b1;
    do_reset();
    @(negedge clk);
    while (!(mem_req_o && mem_addr_o == 32'h8) && k < 60) begin @(negedge clk); k++; end
    n_tests++; if (mem_addr_o !== 32'h8) begin n_fail++; $display("FAIL drain_wait got %h exp 8", mem_addr_o); end
    step();
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    step();
    redirect_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (!mem_req_o || mem_addr_o !== 32'h8) begin
      n_fail++; $display("FAIL drain_hold got req=%b addr %h exp addr 8", mem_req_o, mem_addr_o);
    end
    k = 0;
    while (!(mem_req_o && mem_addr_o == 32'h100) && k < 30) begin @(negedge clk); k++; end
    n_tests++; if (mem_addr_o !== 32'h100) begin n_fail++; $display("FAIL drain_newreq got %h exp 100", mem_addr_o); end
    k = 0;
    while (!instr_valid_o && k < 30) begin @(negedge clk); k++; end
    n_tests++;
    if (!instr_valid_o || instr_pc_o !== 32'h100 || instr_o !== mem_word(32'h100)) begin
      n_fail++; $display("FAIL drain_first got v=%b pc %h exp pc 100", instr_valid_o, instr_pc_o);
    end
  endtask

  task automatic test_redirect_ack();
    ack_lat = 0; instr_ready_i = 1'b1;
    do_reset();
    repeat (4) step();
    redirect_i = 1'b1; redirect_pc_i = 32'h203;
    @(negedge clk);
    n_tests++;
    if (!(mem_ack_i && mem_req_o && instr_valid_o)) begin
      n_fail++; $display("FAIL rack_pre got ack=%b valid=%b exp 1/1", mem_ack_i, instr_valid_o);
    end
    step();
    redirect_i = 1'b0;
    n_tests++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rack_empty got %b exp 0", instr_valid_o); end
    n_tests++;
    if (!mem_req_o || mem_addr_o !== 32'h200) begin
      n_fail++; $display("FAIL rack_addr got req=%b addr %h exp addr 200", mem_req_o, mem_addr_o);
    end
  endtask

  task automatic test_wrap();
    ack_lat = 0; instr_ready_i = 1'b1;
    step();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    n_tests++; if (mem_addr_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top got %h exp fffffffc", mem_addr_o); end
    step();
    n_tests++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL wrap_zero got %h exp 0", mem_addr_o); end
    n_tests++;
    if (!instr_valid_o || instr_pc_o !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_head got v=%b pc %h exp fffffffc", instr_valid_o, instr_pc_o);
    end
  endtask

  task automatic test_reset_midreq();
    int k = 0;
    ack_lat = 5; instr_ready_i = 1'b1;
    do_reset();
    @(negedge clk);
    while (!mem_req_o && k < 10) begin @(negedge clk); k++; end
    #1;
    reset = 1'b0;
    #1;
    n_tests++;
    if (mem_req_o !== 1'b0 || mem_addr_o !== '0 || instr_valid_o !== 1'b0 || instr_o !== '0 || instr_pc_o !== '0) begin
      n_fail++; $display("FAIL midrst_outs got req=%b addr %h v=%b exp all 0", mem_req_o, mem_addr_o, instr_valid_o);
    end
    ack_force = 1'b1;
    step();
    step();
    reset = 1'b1;
    k = 0;
    @(negedge clk);
    while (!mem_req_o && k < 10) begin @(negedge clk); k++; end
    n_tests++;
    if (!mem_req_o || mem_addr_o !== 32'h0) begin
      n_fail++; $display("FAIL midrst_restart got req=%b addr %h exp addr 0", mem_req_o, mem_addr_o);
    end
    step();
    ack_force = 1'b0;
    k = 0;
    while (!instr_valid_o && k < 20) begin @(negedge clk); k++; end
    n_tests++;
    if (!instr_valid_o || instr_pc_o !== 32'h0 || instr_o !== mem_word(32'h0)) begin
      n_fail++; $display("FAIL midrst_first got v=%b pc %h exp pc 0", instr_valid_o, instr_pc_o);
    end
  endtask

  task automatic test_random();
    int pops0;
    ack_rand = 1'b1; ack_lat = 0;
    do_reset();
    pops0 = n_pops;
    for (int c = 0; c < 3000; c++) begin
      instr_ready_i = ($urandom_range(0, 3) != 0);
      redirect_i    = ($urandom_range(0, 19) == 0);
      redirect_pc_i = $urandom;
      if ($urandom_range(0, 99) == 0) ack_lat = $urandom_range(0, 4);
      reset = ($urandom_range(0, 499) != 0);
      step();
    end
    redirect_i = 1'b0; reset = 1'b1; ack_rand = 1'b0;
    repeat (10) step();
    n_tests++;
    if (n_pops - pops0 < 200) begin
      n_fail++; $display("FAIL rand_progress got %0d pops exp >= 200", n_pops - pops0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_ready_stall();
    test_redirect_drain();
    test_redirect_ack();
    test_wrap();
    test_reset_midreq();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
